// File: rtl/const_mult_mod_pipe_if.sv
// ---------------------------------------------------------------------------
// const_mult_mod_pipe_if
// Stream bundle for the pipelined GF(p) constant multiplier.
//   in_valid/in_ready : input beat handshake (beat taken when both high)
//   in_a              : operand, WIDTH bits, expected < P
//   in_k              : multiplier constant, KW bits
//   in_neg            : request -k*a mod p instead of k*a mod p
//   in_tag            : opaque side-band tag, returned with the result
//   out_valid/out_ready : result handshake
//   out_c             : result in [0, P-1]
//   out_err           : k was 0 or above MAX_K (out_c is then 0)
//   out_tag           : tag belonging to this result
// Modports: master = producer/consumer side, slave = multiplier side.
// WORD_SIZE supplies the default operand width when no override is given.
// ---------------------------------------------------------------------------
`ifndef WORD_SIZE
`define WORD_SIZE 8
`endif

interface const_mult_mod_pipe_if #(
  parameter int WIDTH = `WORD_SIZE,
  parameter int KW    = 4,
  parameter int TAG_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [KW-1:0]    in_k;
  logic             in_neg;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_c;
  logic             out_err;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output in_valid, in_a, in_k, in_neg, in_tag, out_ready,
    input  in_ready, out_valid, out_c, out_err, out_tag
  );

  modport slave (
    input  in_valid, in_a, in_k, in_neg, in_tag, out_ready,
    output in_ready, out_valid, out_c, out_err, out_tag
  );
endinterface

// File: rtl/const_mult_mod_pipe.sv
// ---------------------------------------------------------------------------
// const_mult_mod_pipe
// Three-stage pipelined constant multiplier over GF(p):
//   c = k*a mod p   (or -k*a mod p when negation is built in and requested)
// for a run-time constant 1 <= k <= MAX_K. One result per cycle.
//   S1: shift-add product m = k*a (no hard multiplier), error flag for bad k
//   S2: parallel trial subtractions m - j*P, keep the largest non-negative
//   S3: optional negation P - r, registered outputs
// Ports:
//   clk  : clock, all state on the rising edge
//   rst  : synchronous active-high reset; drops every beat in flight
//   bus  : const_mult_mod_pipe_if.slave stream bundle
// Build option:
//   CMM_NEG_EN : when defined, in_neg is honoured and the S3 subtractor is
//                built; when undefined, in_neg is ignored and out_c = r.
// Parameter defaults: WIDTH from WORD_SIZE, P from CHAR.
// Legal configuration: 2 <= MAX_K <= 15, 2**KW > MAX_K, P < 2**WIDTH.
// ---------------------------------------------------------------------------
`ifndef WORD_SIZE
`define WORD_SIZE 8
`endif
`ifndef CHAR
`define CHAR 251
`endif

module const_mult_mod_pipe #(
  parameter int WIDTH = `WORD_SIZE,
  parameter int P     = `CHAR,
  parameter int MAX_K = 8,
  parameter int KW    = 4,
  parameter int TAG_W = 8
) (
  input logic                 clk,
  input logic                 rst,
  const_mult_mod_pipe_if.slave bus
);

  // One extra bit above the largest product so the MSB of each trial
  // difference acts as its sign.
  localparam int PW = WIDTH + $clog2(MAX_K + 1) + 1;

  // -------------------------------------------------------------------------
  // Handshake: every stage moves together whenever the output is free.
  // -------------------------------------------------------------------------
  logic adv;
  logic out_valid_reg;

  assign adv          = !out_valid_reg || bus.out_ready;
  assign bus.in_ready = adv;

  // -------------------------------------------------------------------------
  // S1: shift-add product
  // -------------------------------------------------------------------------
  logic [PW-1:0] pp [KW];
  logic [PW-1:0] m_next;
  logic          err_next;

  generate
    for (genvar gi = 0; gi < KW; gi++) begin : g_pp
      assign pp[gi] = bus.in_k[gi] ? (PW'(bus.in_a) << gi) : '0;
    end
  endgenerate

  always_comb begin
    m_next   = '0;
    err_next = (bus.in_k == '0) || (bus.in_k > KW'(MAX_K));
    for (int i = 0; i < KW; i++) begin
      m_next = m_next + pp[i];
    end
    // A rejected k yields m = 0, so the later stages naturally produce 0.
    if (err_next) begin
      m_next = '0;
    end
  end

  logic             s1_valid_reg;
  logic [PW-1:0]    s1_m_reg;
  logic             s1_err_reg;
  logic [TAG_W-1:0] s1_tag_reg;

  // -------------------------------------------------------------------------
  // S2: reduction by parallel trial subtraction
  // -------------------------------------------------------------------------
  logic [PW-1:0]      diff [1:MAX_K-1];
  logic [MAX_K-1:1]   nonneg;
  logic [PW-1:0]      r_full;
  logic [WIDTH-1:0]   r_next;

  generate
    for (genvar gi = 1; gi < MAX_K; gi++) begin : g_trial
      localparam logic [PW-1:0] JP = PW'(longint'(gi) * longint'(P));
      assign diff[gi]   = s1_m_reg - JP;
      assign nonneg[gi] = ~diff[gi][PW-1];
    end
  endgenerate

  // Since a < P we have m < MAX_K*P, so the largest non-negative trial
  // difference is already below P; later indices override earlier ones.
  always_comb begin
    r_full = s1_m_reg;
    for (int j = 1; j < MAX_K; j++) begin
      if (nonneg[j]) begin
        r_full = diff[j];
      end
    end
  end

  assign r_next = r_full[WIDTH-1:0];

  logic [PW-WIDTH-1:0] unused_r_hi;
  assign unused_r_hi = r_full[PW-1:WIDTH];

  logic             s2_valid_reg;
  logic [WIDTH-1:0] s2_r_reg;
  logic             s2_err_reg;
  logic [TAG_W-1:0] s2_tag_reg;

  // -------------------------------------------------------------------------
  // S3: optional negation
  // -------------------------------------------------------------------------
  logic [WIDTH-1:0] c_next;

`ifdef CMM_NEG_EN
  logic s1_neg_reg;
  logic s2_neg_reg;

  // Zero is its own negative; P - 0 would leave the field range.
  always_comb begin
    c_next = s2_r_reg;
    if (s2_neg_reg && (s2_r_reg != '0)) begin
      c_next = WIDTH'(P) - s2_r_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (adv) begin
      s1_neg_reg <= bus.in_neg;
      s2_neg_reg <= s1_neg_reg;
    end
  end
`else
  logic unused_neg;
  assign unused_neg = bus.in_neg;
  assign c_next     = s2_r_reg;
`endif

  logic [WIDTH-1:0] out_c_reg;
  logic             out_err_reg;
  logic [TAG_W-1:0] out_tag_reg;

  // -------------------------------------------------------------------------
  // Control state and output registers (reset)
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_reg  <= 1'b0;
      s2_valid_reg  <= 1'b0;
      out_valid_reg <= 1'b0;
      out_c_reg     <= '0;
      out_err_reg   <= 1'b0;
      out_tag_reg   <= '0;
    end else if (adv) begin
      // Bubbles advance like beats; nothing is collapsed.
      s1_valid_reg  <= bus.in_valid;
      s2_valid_reg  <= s1_valid_reg;
      out_valid_reg <= s2_valid_reg;
      out_c_reg     <= c_next;
      out_err_reg   <= s2_err_reg;
      out_tag_reg   <= s2_tag_reg;
    end
  end

  // -------------------------------------------------------------------------
  // Pipeline data registers (no reset; qualified by the valid bits)
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (adv) begin
      s1_m_reg   <= m_next;
      s1_err_reg <= err_next;
      s1_tag_reg <= bus.in_tag;
      s2_r_reg   <= r_next;
      s2_err_reg <= s1_err_reg;
      s2_tag_reg <= s1_tag_reg;
    end
  end

  assign bus.out_valid = out_valid_reg;
  assign bus.out_c     = out_c_reg;
  assign bus.out_err   = out_err_reg;
  assign bus.out_tag   = out_tag_reg;

endmodule

// File: tb/tb_const_mult_mod_pipe.sv
module tb_const_mult_mod_pipe;
  localparam int WIDTH = 8;
  localparam int P     = 251;
  localparam int MAX_K = 6;
  localparam int KW    = 4;
  localparam int TAG_W = 8;
`ifdef CMM_NEG_EN
  localparam bit NEG_EN = 1'b1;
`else
  localparam bit NEG_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  const_mult_mod_pipe_if #(.WIDTH(WIDTH), .KW(KW), .TAG_W(TAG_W)) bus ();

  const_mult_mod_pipe #(
    .WIDTH(WIDTH), .P(P), .MAX_K(MAX_K), .KW(KW), .TAG_W(TAG_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic [WIDTH-1:0] c;
    logic             err;
    logic [TAG_W-1:0] tag;
  } exp_t;

  typedef struct {
    int a;
    int k;
    bit neg;
    int tag;
    int exp_c;
    bit exp_err;
  } vec_t;

  exp_t sb_q[$];
  int checks    = 0;
  int errors    = 0;
  int out_count = 0;

  task automatic check(input string name, input longint actual, input longint expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Reference arithmetic: plain integer modulo, independent of the pipeline.
  function automatic exp_t model(input int a, input int k, input bit neg, input int tag);
    exp_t e;
    int   r;
    e.err = (k == 0) || (k > MAX_K);
    r     = e.err ? 0 : (a * k) % P;
    if (NEG_EN && neg && r != 0) r = P - r;
    e.c   = WIDTH'(r);
    e.tag = TAG_W'(tag);
    return e;
  endfunction

  // Output monitor / scoreboard
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      sb_q.delete();
    end else if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      out_count++;
      if (sb_q.size() == 0) begin
        check("unexpected_output", 1, 0);
      end else begin
        e = sb_q.pop_front();
        $display("out: tag=0x%02h c=%0d err=%0d (expected c=%0d err=%0d)",
                 bus.out_tag, bus.out_c, bus.out_err, e.c, e.err);
        check("out_c", bus.out_c, e.c);
        check("out_err", bus.out_err, e.err);
        check("out_tag", bus.out_tag, e.tag);
      end
    end
  end

  // Drive one beat; called just after a rising edge. Returns just after the
  // edge that accepted it.
  task automatic send(input int a, input int k, input bit neg, input int tag,
                      input int exp_c, input bit exp_err);
    exp_t e;
    bit   done;
    done         = 1'b0;
    bus.in_a     = WIDTH'(a);
    bus.in_k     = KW'(k);
    bus.in_neg   = neg;
    bus.in_tag   = TAG_W'(tag);
    bus.in_valid = 1'b1;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (bus.in_ready === 1'b1) begin
        e.c   = WIDTH'(exp_c);
        e.err = exp_err;
        e.tag = TAG_W'(tag);
        sb_q.push_back(e);
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    if (!done) check("send_timeout", 0, 1);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 200 && sb_q.size() != 0; i++) begin
      @(posedge clk);
      #1;
    end
    check("drain_queue_empty", sb_q.size(), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[12];
    int   cnt0;
    int   cnt1;

    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_k      = '0;
    bus.in_neg    = 1'b0;
    bus.in_tag    = '0;
    bus.out_ready = 1'b1;

    // ---------------- reset state ----------------
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_c", bus.out_c, 0);
    check("rst_out_err", bus.out_err, 0);
    check("rst_out_tag", bus.out_tag, 0);
    check("rst_in_ready", bus.in_ready, 1);

    // ---------------- latency: accept edge + two more edges ----------------
    bus.in_a = 8'd200; bus.in_k = 4'd6; bus.in_neg = 1'b0; bus.in_tag = 8'h11;
    bus.in_valid = 1'b1;
    check("lat_in_ready", bus.in_ready, 1);
    sb_q.push_back('{c: 8'd196, err: 1'b0, tag: 8'h11});
    @(posedge clk); #1 bus.in_valid = 1'b0;
    check("lat_after_accept", bus.out_valid, 0);
    @(posedge clk); #1;
    check("lat_after_2nd_edge", bus.out_valid, 0);
    @(posedge clk); #1;
    check("lat_after_3rd_edge", bus.out_valid, 1);
    wait_drain();

    // ---------------- table-driven vectors ----------------
    tbl[0]  = '{200,  6, 1'b0, 8'h30, 196, 1'b0};
    tbl[1]  = '{100,  3, 1'b1, 8'h31, NEG_EN ? 202 : 49, 1'b0};
    tbl[2]  = '{  0,  5, 1'b1, 8'h32, 0, 1'b0};
    tbl[3]  = '{250,  1, 1'b1, 8'h33, NEG_EN ? 1 : 250, 1'b0};
    tbl[4]  = '{250,  6, 1'b0, 8'h34, 245, 1'b0};
    tbl[5]  = '{  7,  7, 1'b0, 8'h35, 0, 1'b1};
    tbl[6]  = '{  9,  0, 1'b1, 8'h36, 0, 1'b1};
    tbl[7]  = '{123, 15, 1'b0, 8'h37, 0, 1'b1};
    tbl[8]  = '{ 17,  2, 1'b0, 8'h38, 34, 1'b0};
    tbl[9]  = '{250,  5, 1'b1, 8'h39, NEG_EN ? 5 : 246, 1'b0};
    tbl[10] = '{  1,  6, 1'b1, 8'h3a, NEG_EN ? 245 : 6, 1'b0};
    tbl[11] = '{126,  2, 1'b0, 8'h3b, 1, 1'b0};
    for (int i = 0; i < 12; i++) begin
      send(tbl[i].a, tbl[i].k, tbl[i].neg, tbl[i].tag, tbl[i].exp_c, tbl[i].exp_err);
    end
    wait_drain();

    // ---------------- back-pressure ----------------
    cnt0 = out_count;
    bus.out_ready = 1'b1;
    fork
      begin
        for (int i = 1; i <= 4; i++) send(i, 2, 1'b0, 8'h40 + i, 2 * i, 1'b0);
      end
      begin
        int waited;
        waited = 0;
        while (bus.out_valid !== 1'b1 && waited < 20) begin
          @(posedge clk); #1;
          waited++;
        end
        check("bp_first_valid", bus.out_valid, 1);
        bus.out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
          @(negedge clk);
          check("bp_in_ready_low", bus.in_ready, 0);
          check("bp_out_valid_held", bus.out_valid, 1);
          check("bp_out_c_held", bus.out_c, 2);
          check("bp_out_tag_held", bus.out_tag, 8'h41);
        end
        @(posedge clk); #1 bus.out_ready = 1'b1;
      end
    join
    wait_drain();
    check("bp_output_count", out_count - cnt0, 4);

    // ---------------- reset mid-stream ----------------
    cnt0 = out_count;
    send(5, 3, 1'b0, 8'h50, 15, 1'b0);
    send(6, 3, 1'b0, 8'h51, 18, 1'b0);
    send(7, 3, 1'b0, 8'h52, 21, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    check("mid_rst_out_valid", bus.out_valid, 0);
    check("mid_rst_in_ready", bus.in_ready, 1);
    check("mid_rst_dropped", out_count - cnt0, 0);
    cnt1 = out_count;
    send(10, 4, 1'b0, 8'h60, 40, 1'b0);
    wait_drain();
    repeat (5) @(posedge clk);
    #1;
    check("mid_rst_single_output", out_count - cnt1, 1);

    // ---------------- random stream with random back-pressure ----------------
    cnt0 = out_count;
    fork
      begin
        int   a;
        int   k;
        int   tg;
        bit   ng;
        exp_t e;
        for (int i = 0; i < 40; i++) begin
          a  = int'($urandom_range(0, P - 1));
          k  = int'($urandom_range(0, 15));
          ng = 1'($urandom_range(0, 1));
          tg = 8'h80 + i;
          e  = model(a, k, ng, tg);
          send(a, k, ng, tg, int'(e.c), e.err);
        end
      end
      begin
        for (int i = 0; i < 150; i++) begin
          @(posedge clk); #1;
          bus.out_ready = ($urandom_range(0, 3) != 0);
        end
        bus.out_ready = 1'b1;
      end
    join
    wait_drain();
    check("rand_output_count", out_count - cnt0, 40);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
